axi_master_rd_split: RTL and testbench

Parametrised AXI4 read master for the engine datapath. It issues a programmed stream of read bursts, splits them so no burst crosses a 4 KB boundary, and throttles on a configurable outstanding-burst limit. It checks returned data against an incrementing pattern and reports completion and errors. It sits between the engine control registers and the host AXI read port.

---
 rtl/axi_master_rd_split.sv | 196 +++++++++++++++++++
 tb/tb_axi_master_rd_split.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_rd_split.sv
// axi_master_rd_split: AXI4 read master issuing a programmed burst stream split on 4 KB pages,
// throttled by an outstanding-burst limit, with incrementing-pattern data checking.
`default_nettype none

module axi_master_rd_split #(
  parameter int ID_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int ARUSER_WIDTH    = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             i_snap_context,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic [1:0]              m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    engine_start_pulse,
  input  logic [63:0]             source_address,
  input  logic [2:0]              rd_size,
  input  logic [7:0]              rd_len,
  input  logic [31:0]             rd_number,
  input  logic [31:0]             rd_init_data,
  input  logic                    check_enable,
  output logic                    rd_busy,
  output logic                    rd_done_pulse,
  output logic [1:0]              rd_error,
  output logic [63:0]             rd_error_info
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  state_t                state, state_nxt;
  logic [2:0]            cfg_size;
  logic [7:0]            cfg_len;
  logic [31:0]           cfg_init;
  logic                  cfg_check;
  logic [40:0]           total;
  logic [40:0]           issue_rem;
  logic [40:0]           rx_count;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            outstanding;

  // Beats in one burst: limited by what is left to issue, the nominal length and the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [40:0] rem, input logic [7:0] len,
                                             input logic [11:0] off, input logic [2:0] size);
    logic [12:0] page;
    logic [8:0]  b;
    page = (13'd4096 - {1'b0, off}) >> size;
    b    = {1'b0, len} + 9'd1;
    if (page < {4'd0, b}) b = page[8:0];
    if (rem < {32'd0, b}) b = rem[8:0];
    return b;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_step(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [8:0] b, input logic [2:0] size);
    return a + ({{(ADDR_WIDTH-9){1'b0}}, b} << size);
  endfunction

  logic        start, aligned, in_run, ar_hs, r_hs, beat_hs, last_hs, rx_final, launch;
  logic        err_data, err_bus;
  logic [40:0] total_w;
  logic [63:0] align_mask;
  logic [8:0]  first_beats, nxt_beats, first_len, nxt_len;
  logic [7:0]  out_nxt;

  assign start       = engine_start_pulse && (state == S_IDLE);
  assign total_w     = {9'd0, rd_number} * {32'd0, ({1'b0, rd_len} + 9'd1)};
  assign align_mask  = (64'd1 << rd_size) - 64'd1;
  assign aligned     = (source_address & align_mask) == 64'd0;
  assign first_beats = burst_beats(total_w, rd_len, source_address[11:0], rd_size);
  assign first_len   = first_beats - 9'd1;
  assign nxt_beats   = burst_beats(issue_rem, cfg_len, next_addr[11:0], cfg_size);
  assign nxt_len     = nxt_beats - 9'd1;

  assign in_run   = (state == S_RUN);
  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign r_hs     = m_axi_rvalid && m_axi_rready;
  assign beat_hs  = r_hs && in_run;
  assign last_hs  = beat_hs && m_axi_rlast;
  assign out_nxt  = outstanding + {7'd0, ar_hs} - {7'd0, last_hs};
  assign rx_final = beat_hs && ((rx_count + 41'd1) == total);
  // A new AR is presented only if the count it will see next cycle is still below the limit.
  assign launch   = in_run && (!m_axi_arvalid || ar_hs) && (issue_rem != 41'd0) && (out_nxt < MAX_OUT);

  assign err_data = beat_hs && cfg_check && (m_axi_rdata[31:0] != (cfg_init + rx_count[31:0]));
  assign err_bus  = r_hs && ((m_axi_rresp != 2'b00) || !in_run);

  assign m_axi_arsize   = cfg_size;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arlock   = 2'b00;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;
  assign m_axi_aruser   = i_snap_context[ARUSER_WIDTH-1:0];
  assign m_axi_rready   = ~rst;
  assign rd_busy        = (state != S_IDLE);
  assign rd_done_pulse  = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = ((total_w == 41'd0) || !aligned) ? S_DONE : S_RUN;
      S_RUN:   if (rx_final) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_size      <= '0;
      cfg_len       <= '0;
      cfg_init      <= '0;
      cfg_check     <= 1'b0;
      total         <= '0;
      issue_rem     <= '0;
      rx_count      <= '0;
      next_addr     <= '0;
      outstanding   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arid    <= '0;
      rd_error      <= '0;
      rd_error_info <= '0;
    end else if (start) begin
      cfg_size      <= rd_size;
      cfg_len       <= rd_len;
      cfg_init      <= rd_init_data;
      cfg_check     <= check_enable;
      total         <= total_w;
      rx_count      <= '0;
      outstanding   <= '0;
      m_axi_arid    <= '0;
      rd_error      <= {~aligned, 1'b0};
      rd_error_info <= '0;
      m_axi_araddr  <= source_address[ADDR_WIDTH-1:0];
      m_axi_arlen   <= first_len[7:0];
      next_addr     <= addr_step(source_address[ADDR_WIDTH-1:0], first_beats, rd_size);
      if (aligned && (total_w != 41'd0)) begin
        m_axi_arvalid <= 1'b1;
        issue_rem     <= total_w - {32'd0, first_beats};
      end else begin
        m_axi_arvalid <= 1'b0;
        issue_rem     <= '0;
      end
    end else begin
      if (ar_hs) m_axi_arid <= m_axi_arid + 1'b1;
      if (launch) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= next_addr;
        m_axi_arlen   <= nxt_len[7:0];
        next_addr     <= addr_step(next_addr, nxt_beats, cfg_size);
        issue_rem     <= issue_rem - {32'd0, nxt_beats};
      end else if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
      end
      outstanding <= out_nxt;
      if (beat_hs) rx_count <= rx_count + 41'd1;
      rd_error <= rd_error | {err_bus, err_data};
      if ((err_bus || err_data) && (rd_error == 2'b00))
        rd_error_info <= {rx_count[31:0], m_axi_rdata[31:0]};
    end
  end

  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi_rid, m_axi_rdata, i_snap_context, source_address};

endmodule

`default_nettype wire

// File: tb/tb_axi_master_rd_split.sv
// tb_axi_master_rd_split: directed bench with a responsive AXI read slave model and immediate assertions.
`default_nettype none

module tb_axi_master_rd_split;

  logic        clk, rst;
  logic [31:0] i_snap_context;
  logic [1:0]  m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [1:0]  m_axi_arlock;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic [3:0]  m_axi_arregion;
  logic [7:0]  m_axi_aruser;
  logic        m_axi_arvalid, m_axi_arready;
  logic [1:0]  m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        engine_start_pulse;
  logic [63:0] source_address;
  logic [2:0]  rd_size;
  logic [7:0]  rd_len;
  logic [31:0] rd_number, rd_init_data;
  logic        check_enable;
  logic        rd_busy, rd_done_pulse;
  logic [1:0]  rd_error;
  logic [63:0] rd_error_info;

  axi_master_rd_split #(.ID_WIDTH(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .ARUSER_WIDTH(8),
                        .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .i_snap_context(i_snap_context),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .engine_start_pulse(engine_start_pulse), .source_address(source_address),
    .rd_size(rd_size), .rd_len(rd_len), .rd_number(rd_number), .rd_init_data(rd_init_data),
    .check_enable(check_enable), .rd_busy(rd_busy), .rd_done_pulse(rd_done_pulse),
    .rd_error(rd_error), .rd_error_info(rd_error_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int rdy; logic [7:0] len; logic [1:0] id;} ar_t;
  ar_t q[$];
  ar_t cur;

  int checks = 0, errors = 0;
  int cyc = 0, last_beat_cyc = 0, sent = 0, run_beats = 0, ar_n = 0;
  int out_m = 0, max_out = 0, stab_viol = 0, stray_done = 0, bcnt = 0, idx = 0;
  int r_delay = 0, ar_throttle = 0, stray_req = 0, beat_base = 0, ar_base = 0, rb_base = 0;
  int bad_beat = -1, resp_beat = -1;
  logic [31:0] bad_data = 32'h0, data_init = 32'h0;
  logic        active = 1'b0, pend = 1'b0, r_stray = 1'b0, ar_hs_m, rl_m;
  logic [63:0] p_addr;
  logic [7:0]  p_len;
  logic [1:0]  p_id;
  logic [63:0] ar_addr_log [128];
  logic [7:0]  ar_len_log  [128];
  logic [1:0]  ar_id_log   [128];

  // Slave model: monitors AR/R on the rising edge, drives R beats and arready on the falling edge.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      cyc++;
      if (rst) begin
        q.delete(); out_m = 0; pend = 1'b0; active = 1'b0;
      end else begin
        ar_hs_m = m_axi_arvalid && m_axi_arready;
        if (pend && (m_axi_arvalid !== 1'b1 || m_axi_araddr !== p_addr ||
                     m_axi_arlen !== p_len || m_axi_arid !== p_id)) stab_viol++;
        pend = m_axi_arvalid && !m_axi_arready;
        p_addr = m_axi_araddr; p_len = m_axi_arlen; p_id = m_axi_arid;
        if (ar_hs_m) begin
          ar_addr_log[ar_n] = m_axi_araddr; ar_len_log[ar_n] = m_axi_arlen; ar_id_log[ar_n] = m_axi_arid;
          ar_n++;
          q.push_back('{rdy: cyc + r_delay, len: m_axi_arlen, id: m_axi_arid});
        end
        rl_m = 1'b0;
        if (m_axi_rvalid && m_axi_rready && !r_stray) begin
          run_beats++; last_beat_cyc = cyc; rl_m = m_axi_rlast;
        end
        out_m = out_m + int'(ar_hs_m) - int'(rl_m);
        if (out_m > max_out) max_out = out_m;
      end
    end else begin
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; r_stray = 1'b0;
      m_axi_arready = (ar_throttle != 0) ? ((cyc % 3) == 0) : 1'b1;
      if (!rst) begin
        if (stray_req != stray_done) begin
          m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'h0000_0000_5757_0000;
          m_axi_rid = 2'd0; r_stray = 1'b1; stray_done++;
        end else begin
          if (!active && q.size() > 0 && cyc >= q[0].rdy) begin
            cur = q.pop_front(); active = 1'b1; bcnt = 0;
          end
          if (active) begin
            idx = sent - beat_base;
            m_axi_rdata = {32'hA5A5_5A5A, data_init + 32'(idx)};
            if (idx == bad_beat) m_axi_rdata[31:0] = bad_data;
            m_axi_rresp = (idx == resp_beat) ? 2'b10 : 2'b00;
            m_axi_rid = cur.id;
            m_axi_rlast = (bcnt == int'(cur.len));
            m_axi_rvalid = 1'b1;
            sent++; bcnt++;
            if (m_axi_rlast) active = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [2:0] s, input logic [7:0] l,
                            input logic [31:0] n, input logic [31:0] init, input logic ce);
    source_address = a; rd_size = s; rd_len = l; rd_number = n;
    rd_init_data = init; check_enable = ce; data_init = init;
    beat_base = sent; ar_base = ar_n; rb_base = run_beats;
    engine_start_pulse = 1'b1;
    @(negedge clk);
    engine_start_pulse = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (rd_done_pulse !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
    end
    chk({tag, "_no_timeout"}, 128'(n < 3000), 128'(1));
    chk({tag, "_done_after_last_beat"}, 128'(cyc), 128'(last_beat_cyc));
    chk({tag, "_busy_in_done"}, 128'(rd_busy), 128'(1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 128'({rd_done_pulse, rd_busy}), 128'(2'b00));
  endtask

  initial begin
    int n;
    rst = 1'b1; engine_start_pulse = 1'b0; i_snap_context = 32'h0000_00C3;
    source_address = '0; rd_size = '0; rd_len = '0; rd_number = '0;
    rd_init_data = '0; check_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ar", 128'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid}), 128'(0));
    chk("reset_status", 128'({m_axi_rready, rd_busy, rd_done_pulse, rd_error, rd_error_info}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rready_out_of_reset", 128'(m_axi_rready), 128'(1));

    // Four aligned bursts of 4 x 64 B beats
    start_xfer(64'h1000, 3'd6, 8'd3, 32'd4, 32'h10, 1'b1);
    chk("t1_first_ar", 128'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid}),
        128'({1'b1, 64'h1000, 8'd3, 2'd0}));
    chk("t1_aruser_arsize", 128'({m_axi_aruser, m_axi_arsize, m_axi_arburst, m_axi_arcache}),
        128'({8'hC3, 3'd6, 2'd1, 4'd3}));
    wait_done("t1");
    chk("t1_ar_count", 128'(ar_n - ar_base), 128'(4));
    for (int i = 0; i < 4; i++)
      chk("t1_ar_fields", 128'({ar_addr_log[ar_base+i], ar_len_log[ar_base+i], ar_id_log[ar_base+i]}),
          128'({64'h1000 + 64'(i) * 64'h100, 8'd3, 2'(i)}));
    chk("t1_beats", 128'(run_beats - rb_base), 128'(16));
    chk("t1_rd_error", 128'(rd_error), 128'(0));

    // 4 KB split: one beat before the page end, three after; data check disabled
    bad_beat = 2; bad_data = 32'hBAD0_0000;
    start_xfer(64'h0FC0, 3'd6, 8'd3, 32'd1, 32'h0, 1'b0);
    wait_done("t2");
    chk("t2_ar_count", 128'(ar_n - ar_base), 128'(2));
    chk("t2_ar0", 128'({ar_addr_log[ar_base], ar_len_log[ar_base], ar_id_log[ar_base]}),
        128'({64'h0FC0, 8'd0, 2'd0}));
    chk("t2_ar1", 128'({ar_addr_log[ar_base+1], ar_len_log[ar_base+1], ar_id_log[ar_base+1]}),
        128'({64'h1000, 8'd2, 2'd1}));
    chk("t2_beats", 128'(run_beats - rb_base), 128'(4));
    chk("t2_no_check_error", 128'(rd_error), 128'(0));
    bad_beat = -1;

    // Slow R and throttled AR: outstanding limit, AR stability and ID wrap
    r_delay = 20; ar_throttle = 1;
    start_xfer(64'h2000, 3'd3, 8'd1, 32'd6, 32'h100, 1'b1);
    wait_done("t3");
    chk("t3_ar_count", 128'(ar_n - ar_base), 128'(6));
    for (int i = 0; i < 6; i++)
      chk("t3_ar_fields", 128'({ar_addr_log[ar_base+i], ar_len_log[ar_base+i], ar_id_log[ar_base+i]}),
          128'({64'h2000 + 64'(i) * 64'h10, 8'd1, 2'(i % 4)}));
    chk("t3_max_outstanding", 128'(max_out), 128'(2));
    chk("t3_ar_stable", 128'(stab_viol), 128'(0));
    chk("t3_rd_error", 128'(rd_error), 128'(0));
    r_delay = 0; ar_throttle = 0;

    // Data mismatch on beat 5, then RRESP error on beat 9
    bad_beat = 5; bad_data = 32'h0000_DEAD; resp_beat = 9;
    start_xfer(64'h0, 3'd2, 8'd7, 32'd2, 32'h0, 1'b1);
    n = 0;
    while ((run_beats - rb_base) < 7 && n < 500) begin @(negedge clk); n++; end
    chk("t4_mid_error", 128'(rd_error), 128'(2'b01));
    chk("t4_mid_info", 128'(rd_error_info), 128'({32'd5, 32'h0000_DEAD}));
    wait_done("t4");
    chk("t4_final_error", 128'(rd_error), 128'(2'b11));
    chk("t4_info_kept", 128'(rd_error_info), 128'({32'd5, 32'h0000_DEAD}));
    bad_beat = -1; resp_beat = -1;

    // Zero bursts: done on the cycle after start, no AR; start clears old errors
    start_xfer(64'h3000, 3'd6, 8'd3, 32'd0, 32'h0, 1'b1);
    chk("t5_zero_done", 128'({rd_done_pulse, rd_busy, m_axi_arvalid, rd_error}), 128'({1'b1, 1'b1, 1'b0, 2'b00}));
    @(negedge clk);
    chk("t5_zero_idle", 128'({rd_done_pulse, rd_busy, m_axi_arvalid}), 128'(0));
    chk("t5_zero_no_ar", 128'(ar_n - ar_base), 128'(0));

    // Misaligned start address
    start_xfer(64'h1004, 3'd3, 8'd0, 32'd2, 32'h0, 1'b1);
    chk("t6_misaligned", 128'({rd_done_pulse, m_axi_arvalid, rd_error}), 128'({1'b1, 1'b0, 2'b10}));
    @(negedge clk);
    chk("t6_no_ar", 128'({ar_n - ar_base, 1'(rd_busy)}), 128'({32'd0, 1'b0}));

    // Reset in the middle of a transfer, stray beat afterwards, then a clean run
    r_delay = 20;
    start_xfer(64'h1000, 3'd6, 8'd3, 32'd4, 32'h10, 1'b1);
    repeat (8) @(negedge clk);
    chk("t7_busy_before_rst", 128'(rd_busy), 128'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_ar", 128'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid}), 128'(0));
    chk("t7_rst_status", 128'({m_axi_rready, rd_busy, rd_done_pulse, rd_error, rd_error_info}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    r_delay = 0;
    @(negedge clk);
    stray_req++;
    repeat (4) @(negedge clk);
    chk("t7_stray_error", 128'({rd_error, rd_busy}), 128'({2'b10, 1'b0}));
    start_xfer(64'h1000, 3'd6, 8'd3, 32'd4, 32'h20, 1'b1);
    chk("t7_start_clears", 128'({rd_error, m_axi_arid, m_axi_arvalid}), 128'({2'b00, 2'd0, 1'b1}));
    wait_done("t7");
    chk("t7_ar_count", 128'(ar_n - ar_base), 128'(4));
    chk("t7_last_ar", 128'({ar_addr_log[ar_base+3], ar_id_log[ar_base+3]}), 128'({64'h1300, 2'd3}));
    chk("t7_beats", 128'(run_beats - rb_base), 128'(16));
    chk("t7_rd_error", 128'(rd_error), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
